// File: rtl/expander_req_arbiter.sv
// -----------------------------------------------------------------------------
// expander_req_arbiter
//   Round-robin arbiter sharing one i2c_expander_sfp control conduit among
//   N_REQ requesters. Each grant issues exactly one device strobe (write O-reg,
//   read I-reg or read O-reg), follows the device ready handshake to completion
//   (ready falls, then rises), and then holds off the next grant for a relax
//   gap of RELAX_TIME cycles.
//
// Parameters
//   N_REQ       number of requesters (2..8)
//   RELAX_TIME  idle cycles after every completed/aborted transaction
//   TIMEOUT     cycles allowed from strobe to completion (timeout build only)
//
// Ports
//   clk_50            in   system clock
//   rst_n             in   asynchronous active-low reset
//   req[N_REQ]        in   level request per requester
//   op[2*N_REQ]       in   op[2i+1:2i]: 00 none, 01 write_o, 10 read_i, 11 read_o
//   gnt[N_REQ]        out  one-cycle one-hot pulse, request accepted
//   done[N_REQ]       out  one-cycle pulse, granted transaction completed
//   err[N_REQ]        out  one-cycle pulse, granted transaction timed out
//   busy              out  high from grant until end of relax gap
//   need_write_reg_o  out  device strobe
//   need_read_reg_i   out  device strobe
//   need_read_reg_o   out  device strobe
//   dev_ready         in   device ready level
//
// Build option
//   EXP_ARB_TIMEOUT_EN : adds the transaction timeout (err pulses). When not
//                        defined the handshake waits forever and err is 0.
// -----------------------------------------------------------------------------
module expander_req_arbiter #(
    parameter int N_REQ      = 4,
    parameter int RELAX_TIME = 1500,
    parameter int TIMEOUT    = 100000
) (
    input  logic               clk_50,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] op,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [N_REQ-1:0]   err,
    output logic               busy,
    output logic               need_write_reg_o,
    output logic               need_read_reg_i,
    output logic               need_read_reg_o,
    input  logic               dev_ready
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int RW = $clog2(RELAX_TIME + 1);

    if (N_REQ < 2 || N_REQ > 8 || RELAX_TIME < 1 || TIMEOUT < 1) begin : g_param_check
        $error("expander_req_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DROP,
        S_WAIT_DONE,
        S_RELAX
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [1:0]       op_q, op_d;
    logic [RW-1:0]    relax_q, relax_d;
    logic             dev_ready_q;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             busy_q, busy_d;
    logic             wr_q, wr_d;
    logic             ri_q, ri_d;
    logic             ro_q, ro_d;

    logic [N_REQ-1:0] elig;
    logic             sel_found;
    logic [IW-1:0]    sel_idx;
    logic             dev_rise;

`ifdef EXP_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]    wait_q, wait_d;
    logic [N_REQ-1:0] err_q, err_d;
    logic             timeout_hit;

    assign timeout_hit = (wait_q == TW'(TIMEOUT - 1));
`endif

    // A request with op 00 carries no work and is never eligible.
    for (genvar i = 0; i < N_REQ; i++) begin : g_elig
        assign elig[i] = req[i] & (op[2*i +: 2] != 2'b00);
    end

    assign dev_rise = dev_ready & ~dev_ready_q;

    // Round-robin search starting just after the last winner.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!sel_found && elig[(int'(ptr_q) + k) % N_REQ]) begin
                sel_found = 1'b1;
                sel_idx   = IW'((int'(ptr_q) + k) % N_REQ);
            end
        end
    end

    // Next state and next registered outputs. Outputs are computed from the
    // current state and appear one cycle later, so gnt/strobe show up on the
    // ISSUE -> WAIT_DROP edge.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        relax_d = '0;
        gnt_d   = '0;
        done_d  = '0;
        wr_d    = 1'b0;
        ri_d    = 1'b0;
        ro_d    = 1'b0;
        busy_d  = (state_q != S_IDLE);
`ifdef EXP_ARB_TIMEOUT_EN
        wait_d  = '0;
        err_d   = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (dev_ready && sel_found) begin
                    idx_d   = sel_idx;
                    ptr_d   = sel_idx;
                    op_d    = op[2*sel_idx +: 2];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                gnt_d[idx_q] = 1'b1;
                wr_d         = (op_q == 2'b01);
                ri_d         = (op_q == 2'b10);
                ro_d         = (op_q == 2'b11);
                state_d      = S_WAIT_DROP;
            end
            S_WAIT_DROP: begin
`ifdef EXP_ARB_TIMEOUT_EN
                wait_d = wait_q + 1'b1;
                if (timeout_hit) begin
                    err_d[idx_q] = 1'b1;
                    state_d      = S_RELAX;
                end else if (!dev_ready) begin
                    state_d = S_WAIT_DONE;
                end
`else
                if (!dev_ready) state_d = S_WAIT_DONE;
`endif
            end
            S_WAIT_DONE: begin
`ifdef EXP_ARB_TIMEOUT_EN
                wait_d = wait_q + 1'b1;
`endif
                // Completion takes priority over a coincident timeout.
                if (dev_rise) begin
                    done_d[idx_q] = 1'b1;
                    state_d       = S_RELAX;
                end
`ifdef EXP_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    err_d[idx_q] = 1'b1;
                    state_d      = S_RELAX;
                end
`endif
            end
            S_RELAX: begin
                if (relax_q == RW'(RELAX_TIME - 1)) state_d = S_IDLE;
                else                                relax_d = relax_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            ptr_q       <= IW'(N_REQ - 1);
            op_q        <= 2'b00;
            relax_q     <= '0;
            dev_ready_q <= 1'b0;
            gnt_q       <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            wr_q        <= 1'b0;
            ri_q        <= 1'b0;
            ro_q        <= 1'b0;
`ifdef EXP_ARB_TIMEOUT_EN
            wait_q      <= '0;
            err_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            op_q        <= op_d;
            relax_q     <= relax_d;
            dev_ready_q <= dev_ready;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            wr_q        <= wr_d;
            ri_q        <= ri_d;
            ro_q        <= ro_d;
`ifdef EXP_ARB_TIMEOUT_EN
            wait_q      <= wait_d;
            err_q       <= err_d;
`endif
        end
    end

    assign gnt              = gnt_q;
    assign done             = done_q;
    assign busy             = busy_q;
    assign need_write_reg_o = wr_q;
    assign need_read_reg_i  = ri_q;
    assign need_read_reg_o  = ro_q;
`ifdef EXP_ARB_TIMEOUT_EN
    assign err              = err_q;
`else
    assign err              = '0;
`endif

endmodule

// File: tb/tb_expander_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_expander_req_arbiter
//   Directed bench for expander_req_arbiter: a vector table of single
//   transactions (grant, strobe, latency, done, relax length), then sequences
//   for round-robin order, ignored op 00, ready-low blocking, timeout,
//   asynchronous reset mid-transaction, and a passive monitor for strobe
//   exclusivity and grant spacing.
// -----------------------------------------------------------------------------
module tb_expander_req_arbiter;

    localparam int NR = 4;
    localparam int RT = 20;
    localparam int TO = 200;

    logic       clk_50 = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] op;
    logic [3:0] gnt, done, err;
    logic       busy, wr, ri, ro;
    logic       dev_ready;

    // Device model select: 0 manual level, 1 normal handshake, 2 never drops.
    logic [1:0] dev_sel;
    logic       man_rdy;
    logic       nrm_rdy  = 1'b1;
    int         dcnt     = 0;
    int         rise_cyc = 0;
    int         cyc      = 0;

    int         checks   = 0;
    int         failures = 0;
    int         mon_bad  = 0;
    int         n_wr = 0, n_ri = 0, n_ro = 0;
    int         end_cyc  = 0;
    logic       have_end = 1'b0;

    typedef struct {
        logic [3:0] r;
        logic [7:0] o;
        logic [3:0] g;
        logic [2:0] s;   // {wr, ri, ro}
    } vec_t;

    vec_t       tbl[4];
    logic [3:0] rr_ord[4];

    expander_req_arbiter #(.N_REQ(NR), .RELAX_TIME(RT), .TIMEOUT(TO)) dut (
        .clk_50(clk_50), .rst_n(rst_n), .req(req), .op(op),
        .gnt(gnt), .done(done), .err(err), .busy(busy),
        .need_write_reg_o(wr), .need_read_reg_i(ri), .need_read_reg_o(ro),
        .dev_ready(dev_ready)
    );

    always #5 clk_50 = ~clk_50;
    always @(posedge clk_50) cyc <= cyc + 1;

    assign dev_ready = (dev_sel == 2'd0) ? man_rdy :
                       (dev_sel == 2'd1) ? nrm_rdy : 1'b1;

    // Normal device: ready drops 2 cycles after a strobe, rises 50 later.
    always @(negedge clk_50) begin
        if (dev_sel != 2'd1) begin
            dcnt    = 0;
            nrm_rdy = 1'b1;
        end else begin
            if (wr | ri | ro)              dcnt = 1;
            else if (dcnt != 0 && dcnt < 60) dcnt++;
            else                           dcnt = 0;
            if (dcnt == 3) nrm_rdy = 1'b0;
            if (dcnt == 53) begin
                nrm_rdy  = 1'b1;
                rise_cyc = cyc;
            end
        end
    end

    // Passive monitor: strobe exclusivity, strobe only with grant, one-hot
    // grant, minimum spacing from done/err to the next grant.
    always @(negedge clk_50) begin
        if (!rst_n) begin
            have_end = 1'b0;
        end else begin
            if ($countones({wr, ri, ro}) > 1) mon_bad++;
            if (({wr, ri, ro} != 3'b000) != (gnt != 4'b0000)) mon_bad++;
            if ($countones(gnt) > 1) mon_bad++;
            if (gnt != 0 && have_end && (cyc - end_cyc) < RT + 1) mon_bad++;
            if (done != 0 || err != 0) begin
                end_cyc  = cyc;
                have_end = 1'b1;
            end
            n_wr += int'(wr);
            n_ri += int'(ri);
            n_ro += int'(ro);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_gnt(input int lim, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk_50);
            if (gnt != 0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_end(input int lim, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk_50);
            if (done != 0 || err != 0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(input int lim, output int k);
        k = 0;
        while (busy && k < lim) begin
            @(negedge clk_50);
            k++;
        end
    endtask

    task automatic run_txn(input vec_t v, input int id);
        int   t0, k;
        logic ok;
        req = v.r;
        op  = v.o;
        t0  = cyc;
        wait_gnt(50, ok);
        check($sformatf("vec%0d_gnt_seen", id), ok, 1);
        check($sformatf("vec%0d_latency", id), cyc - t0, 2);
        check($sformatf("vec%0d_gnt", id), gnt, v.g);
        check($sformatf("vec%0d_strobe", id), {wr, ri, ro}, v.s);
        req = '0;
        @(negedge clk_50);
        check($sformatf("vec%0d_pulse_len", id), {gnt, wr, ri, ro}, 0);
        wait_end(200, ok);
        check($sformatf("vec%0d_done_seen", id), ok, 1);
        check($sformatf("vec%0d_done", id), done, v.g);
        check($sformatf("vec%0d_err", id), err, 0);
        check($sformatf("vec%0d_done_after_rise", id), cyc - rise_cyc, 1);
        wait_idle(RT + 10, k);
        check($sformatf("vec%0d_relax_len", id), (k >= RT && k <= RT + 2), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t0, k, bad, dcyc, g_cyc;
        int   wr0, ri0, ro0;
        logic ok;

        tbl[0] = '{4'b0001, 8'b00_00_00_01, 4'b0001, 3'b100};
        tbl[1] = '{4'b0010, 8'b00_00_10_00, 4'b0010, 3'b010};
        tbl[2] = '{4'b0100, 8'b00_11_00_00, 4'b0100, 3'b001};
        tbl[3] = '{4'b1000, 8'b10_00_00_00, 4'b1000, 3'b010};
        rr_ord[0] = 4'b1000;
        rr_ord[1] = 4'b0001;
        rr_ord[2] = 4'b0010;
        rr_ord[3] = 4'b0100;

        rst_n   = 1'b0;
        req     = '0;
        op      = '0;
        dev_sel = 2'd1;
        man_rdy = 1'b1;
        repeat (3) @(negedge clk_50);
        check("reset_outputs", {gnt, done, err, busy, wr, ri, ro}, 0);
        rst_n = 1'b1;
        @(negedge clk_50);

        // Single transactions, all three op codes.
        wr0 = n_wr; ri0 = n_ri; ro0 = n_ro;
        for (int i = 0; i < 4; i++) run_txn(tbl[i], i);
        check("op_cov_wr", n_wr - wr0, 1);
        check("op_cov_ri", n_ri - ri0, 2);
        check("op_cov_ro", n_ro - ro0, 1);

        // Two simultaneous requests, last winner was 3 -> 0 then 2.
        req = 4'b0101;
        op  = 8'b00_01_00_01;
        wait_gnt(50, ok);
        check("rr2_first", gnt, 4'b0001);
        req[0] = 1'b0;
        wait_end(200, ok);
        wait_gnt(RT + 50, ok);
        check("rr2_second", gnt, 4'b0100);
        req[2] = 1'b0;
        wait_end(200, ok);
        wait_idle(RT + 10, k);

        // All four held high: pointer at 2 -> 3,0,1,2 with relax spacing.
        req  = 4'b1111;
        op   = 8'h55;
        dcyc = 0;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(RT + 60, ok);
            check($sformatf("rr4_gnt%0d", i), gnt, rr_ord[i]);
            if (i > 0) check($sformatf("rr4_gap%0d", i), (cyc - dcyc) >= RT + 1, 1);
            if (i == 3) req = '0;
            wait_end(200, ok);
            dcyc = cyc;
        end
        wait_idle(RT + 10, k);

        // op 00 is never granted.
        req = 4'b0010;
        op  = 8'h00;
        bad = 0;
        repeat (5000) begin
            @(negedge clk_50);
            if (gnt != 0 || {wr, ri, ro} != 0 || busy) bad++;
        end
        check("op00_ignored", bad, 0);

        // Ready low in IDLE blocks the grant until it rises.
        man_rdy = 1'b0;
        dev_sel = 2'd0;
        req     = 4'b1010;
        op      = 8'b01_00_00_00;
        bad     = 0;
        repeat (100) begin
            @(negedge clk_50);
            if (gnt != 0) bad++;
        end
        check("rdy_low_blocks", bad, 0);
        man_rdy = 1'b1;
        t0 = cyc;
        wait_gnt(20, ok);
        check("rdy_high_gnt", gnt, 4'b1000);
        check("rdy_high_latency", cyc - t0, 2);
        req = 4'b0010;
        repeat (2) @(negedge clk_50);
        man_rdy = 1'b0;
        repeat (10) @(negedge clk_50);
        man_rdy = 1'b1;
        wait_end(20, ok);
        check("manual_done", done, 4'b1000);
        wait_idle(RT + 10, k);
        req = '0;

        // Device never drops ready.
        dev_sel = 2'd2;
        req     = 4'b0001;
        op      = 8'b00_00_00_01;
        wait_gnt(50, ok);
        g_cyc = cyc;
        check("stuck_gnt", gnt, 4'b0001);
        req = '0;
`ifdef EXP_ARB_TIMEOUT_EN
        wait_end(TO + 100, ok);
        check("timeout_seen", ok, 1);
        check("timeout_err", err, 4'b0001);
        check("timeout_no_done", done, 0);
        check("timeout_time", cyc - g_cyc, TO);
        req = 4'b0010;
        op  = 8'b00_00_10_00;
        wait_gnt(RT + 20, ok);
        check("after_timeout_gnt", gnt, 4'b0010);
        req = '0;
`else
        bad = 0;
        repeat (500) begin
            @(negedge clk_50);
            if (err != 0 || done != 0 || !busy) bad++;
        end
        check("no_timeout_stays_busy", bad, 0);
`endif

        // Move into WAIT_DONE, then reset asynchronously.
        man_rdy = 1'b1;
        dev_sel = 2'd0;
        @(negedge clk_50);
        man_rdy = 1'b0;
        repeat (5) @(negedge clk_50);
        #2 rst_n = 1'b0;
        #1 check("reset_mid_txn", {gnt, done, err, busy, wr, ri, ro}, 0);
        man_rdy = 1'b1;
        repeat (3) @(negedge clk_50);
        rst_n = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk_50);
            if (done != 0 || busy) bad++;
        end
        check("no_done_after_reset", bad, 0);

        dev_sel = 2'd1;
        req = 4'b0101;
        op  = 8'b00_01_00_01;
        wait_gnt(50, ok);
        check("post_reset_first", gnt, 4'b0001);
        req = 4'b0100;
        wait_end(200, ok);
        check("post_reset_done", done, 4'b0001);
        wait_gnt(RT + 50, ok);
        check("post_reset_second", gnt, 4'b0100);
        req = '0;
        wait_end(200, ok);
        wait_idle(RT + 10, k);

        check("monitor_violations", mon_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
